grf_wb_sink: RTL and testbench

- W-stage register file write port and general register file.
- Consumes the writeback control bundle (write enable, destination select, data select, load-extension op) plus raw W-stage operands.
- Performs load byte/halfword extraction and extension, commits to the 32x32 GRF, and serves two combinational read ports with optional same-cycle write bypass.
- Optionally logs every committed write into a trace FIFO drained by the testbench or debug port.

---
 rtl/grf_wb_sink.sv | 173 +++++++++++++++++
 tb/tb_grf_wb_sink.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grf_wb_sink.sv
// grf_wb_sink: W-stage register file write port plus the 32x32 GRF.
// Extracts and extends load data, commits to the array, and serves two
// combinational read ports. BYPASS=1 lets a read of the register being
// written this cycle see the new value.
// Optional feature macro GRF_TRACE_EN: when defined, every committed write is
// logged into a TRACE_DEPTH-entry FIFO; when undefined, trace outputs are 0.
//
// Trace handshake: an entry transfers on a posedge where trace_valid and
// trace_ready are both high. trace_valid never depends on trace_ready, and the
// head fields stay stable while trace_valid is high and no transfer occurs.
module grf_wb_sink #(
  parameter bit BYPASS      = 1'b1,
  parameter int TRACE_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_we,
  input  logic [1:0]  w_wreg_sel,
  input  logic [1:0]  w_wdata_sel,
  input  logic [2:0]  w_xext_op,
  input  logic [4:0]  w_rt,
  input  logic [4:0]  w_rd,
  input  logic [31:0] w_alu,
  input  logic [31:0] w_mem,
  input  logic [31:0] w_pc,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [4:0]  trace_reg,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);

  logic [31:0] regs [32];
  logic [4:0]  dest;
  logic        commit;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_data;
  logic [31:0] wdata;

  // Destination select; sel 3 means no write and maps to $0.
  always_comb begin
    dest = 5'd0;
    case (w_wreg_sel)
      2'd0:    dest = w_rt;
      2'd1:    dest = w_rd;
      2'd2:    dest = 5'd31;
      default: dest = 5'd0;
    endcase
  end

  // $0 is never written, so commit already excludes it.
  assign commit = w_we && (w_wreg_sel != 2'd3) && (dest != 5'd0);

  // Load byte/halfword extraction and extension from the raw memory word.
  always_comb begin
    byte_v = 8'h00;
    case (w_alu[1:0])
      2'd0: byte_v = w_mem[7:0];
      2'd1: byte_v = w_mem[15:8];
      2'd2: byte_v = w_mem[23:16];
      2'd3: byte_v = w_mem[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = w_alu[1] ? w_mem[31:16] : w_mem[15:0];
    ext_data = w_mem;
    case (w_xext_op)
      3'd1:    ext_data = {24'h000000, byte_v};
      3'd2:    ext_data = {{24{byte_v[7]}}, byte_v};
      3'd3:    ext_data = {16'h0000, half_v};
      3'd4:    ext_data = {{16{half_v[15]}}, half_v};
      default: ext_data = w_mem;
    endcase
  end

  // Write data mux.
  always_comb begin
    wdata = 32'h0;
    case (w_wdata_sel)
      2'd0:    wdata = w_alu;
      2'd1:    wdata = ext_data;
      2'd2:    wdata = w_pc + 32'd8;
      default: wdata = 32'h0;
    endcase
  end

  // Register array; reset wins over a same-cycle commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (commit) begin
      regs[dest] <= wdata;
    end
  end

  // Combinational reads with optional same-cycle bypass of the committing value.
  always_comb begin
    rd1 = (ra1 == 5'd0) ? 32'h0 : regs[ra1];
    rd2 = (ra2 == 5'd0) ? 32'h0 : regs[ra2];
    if (BYPASS && commit && (ra1 == dest)) rd1 = wdata;
    if (BYPASS && commit && (ra2 == dest)) rd2 = wdata;
  end

`ifdef GRF_TRACE_EN
  localparam int AW = $clog2(TRACE_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TRACE_DEPTH);

  logic [31:0]   fifo_pc   [TRACE_DEPTH];
  logic [4:0]    fifo_reg  [TRACE_DEPTH];
  logic [31:0]   fifo_data [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow_q;
  logic          pop;
  logic          full;
  logic          push_ok;

  assign full    = (count == FULL_CNT);
  assign pop     = (count != '0) && trace_ready;
  // When full, a push still fits if the head leaves in the same cycle.
  assign push_ok = commit && (!full || pop);

  // Trace FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TRACE_DEPTH; i++) begin
        fifo_pc[i]   <= 32'h0;
        fifo_reg[i]  <= 5'd0;
        fifo_data[i] <= 32'h0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_pc[wr_ptr]   <= w_pc;
        fifo_reg[wr_ptr]  <= dest;
        fifo_data[wr_ptr] <= wdata;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (commit && !push_ok) overflow_q <= 1'b1;
    end
  end

  assign trace_valid    = (count != '0);
  assign trace_pc       = fifo_pc[rd_ptr];
  assign trace_reg      = fifo_reg[rd_ptr];
  assign trace_data     = fifo_data[rd_ptr];
  assign trace_overflow = overflow_q;
`else
  logic unused_trace;
  assign unused_trace   = trace_ready | (TRACE_DEPTH > 64);
  assign trace_valid    = 1'b0;
  assign trace_pc       = 32'h0;
  assign trace_reg      = 5'd0;
  assign trace_data     = 32'h0;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_grf_wb_sink.sv
// Testbench for grf_wb_sink: two instances (BYPASS=1 and BYPASS=0) share the
// same stimulus; a behavioural model holds the register contents and the
// expected trace queue. Trace checks follow GRF_TRACE_EN.
module tb_grf_wb_sink;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [1:0]  w_wreg_sel;
  logic [1:0]  w_wdata_sel;
  logic [2:0]  w_xext_op;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_alu;
  logic [31:0] w_mem;
  logic [31:0] w_pc;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic        trace_ready;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        trace_valid, trace_overflow, nb_valid, nb_overflow;
  logic [31:0] trace_pc, trace_data, nb_pc, nb_data;
  logic [4:0]  trace_reg, nb_reg;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  logic [31:0] m_regs [32];
  logic [68:0] exp_q[$];
  logic        m_ovf;

  always #5 clk = ~clk;

  grf_wb_sink #(.BYPASS(1'b1), .TRACE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .w_we(w_we), .w_wreg_sel(w_wreg_sel),
    .w_wdata_sel(w_wdata_sel), .w_xext_op(w_xext_op), .w_rt(w_rt), .w_rd(w_rd),
    .w_alu(w_alu), .w_mem(w_mem), .w_pc(w_pc), .ra1(ra1), .ra2(ra2),
    .rd1(rd1), .rd2(rd2), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_reg(trace_reg), .trace_data(trace_data),
    .trace_overflow(trace_overflow)
  );

  grf_wb_sink #(.BYPASS(1'b0), .TRACE_DEPTH(DEPTH)) dut_nb (
    .clk(clk), .reset(reset), .w_we(w_we), .w_wreg_sel(w_wreg_sel),
    .w_wdata_sel(w_wdata_sel), .w_xext_op(w_xext_op), .w_rt(w_rt), .w_rd(w_rd),
    .w_alu(w_alu), .w_mem(w_mem), .w_pc(w_pc), .ra1(ra1), .ra2(ra2),
    .rd1(rd1_nb), .rd2(rd2_nb), .trace_valid(nb_valid), .trace_ready(trace_ready),
    .trace_pc(nb_pc), .trace_reg(nb_reg), .trace_data(nb_data),
    .trace_overflow(nb_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (from the architectural rules) ----------
  function automatic logic [4:0] model_dest();
    if (w_wreg_sel == 2'd0) return w_rt;
    if (w_wreg_sel == 2'd1) return w_rd;
    if (w_wreg_sel == 2'd2) return 5'd31;
    return 5'd0;
  endfunction

  function automatic bit model_commit();
    return w_we && (w_wreg_sel != 2'd3) && (model_dest() != 5'd0);
  endfunction

  function automatic logic [31:0] model_wdata();
    int unsigned b, h;
    b = (w_mem >> (8 * w_alu[1:0])) & 32'hFF;
    h = (w_mem >> (16 * w_alu[1])) & 32'hFFFF;
    case (w_wdata_sel)
      2'd0: return w_alu;
      2'd2: return w_pc + 32'd8;
      2'd3: return 32'h0;
      default: begin
        case (w_xext_op)
          3'd1: return b;
          3'd2: return (b >= 128) ? b + 32'hFFFFFF00 : b;
          3'd3: return h;
          3'd4: return (h >= 32768) ? h + 32'hFFFF0000 : h;
          default: return w_mem;
        endcase
      end
    endcase
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && model_commit() && a == model_dest()) return model_wdata();
    return m_regs[a];
  endfunction

  // ---------------- driver tasks ---------------------------------------------
  task automatic set_wr(input logic we, input logic [1:0] wsel, input logic [1:0] dsel,
                        input logic [2:0] xop, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    w_we = we; w_wreg_sel = wsel; w_wdata_sel = dsel; w_xext_op = xop;
    w_rt = rt; w_rd = rd; w_alu = alu; w_mem = mem; w_pc = pc;
  endtask

  task automatic set_idle();
    set_wr(1'b0, 2'd3, 2'd0, 3'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Inputs are already applied at the negedge; check outputs, then advance one
  // clock and update the model with what the posedge should have done.
  task automatic cycle();
    bit          cm, pop;
    logic [4:0]  d;
    logic [31:0] wd;
    #1;
    check("rd1", rd1, exp_read(ra1, 1'b1));
    check("rd2", rd2, exp_read(ra2, 1'b1));
    check("rd1_nb", rd1_nb, exp_read(ra1, 1'b0));
    check("rd2_nb", rd2_nb, exp_read(ra2, 1'b0));
`ifdef GRF_TRACE_EN
    check("trace_valid", {31'b0, trace_valid}, {31'b0, exp_q.size() > 0});
    check("trace_overflow", {31'b0, trace_overflow}, {31'b0, m_ovf});
    if (exp_q.size() > 0) begin
      check("trace_pc", trace_pc, exp_q[0][68:37]);
      check("trace_reg", {27'b0, trace_reg}, {27'b0, exp_q[0][36:32]});
      check("trace_data", trace_data, exp_q[0][31:0]);
    end
`else
    check("trace_valid_off", {31'b0, trace_valid}, 32'h0);
    check("trace_ovf_off", {31'b0, trace_overflow}, 32'h0);
    check("trace_bus_off", trace_pc | trace_data | {27'b0, trace_reg}, 32'h0);
`endif
    cm = model_commit(); d = model_dest(); wd = model_wdata();
    pop = trace_ready && (exp_q.size() > 0);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      if (cm) m_regs[d] = wd;
`ifdef GRF_TRACE_EN
      if (pop) void'(exp_q.pop_front());
      if (cm) begin
        if (exp_q.size() < DEPTH) exp_q.push_back({w_pc, d, wd});
        else m_ovf = 1'b1;
      end
`endif
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; set_idle(); trace_ready = 1'b0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  // ---------------- stimulus -------------------------------------------------
  logic [31:0] first8 [8];

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 32'hX;
    m_ovf = 1'b0;
    reset = 1'b1; set_idle(); ra1 = 5'd0; ra2 = 5'd0; trace_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset state and first write
    ra1 = 5'd5; ra2 = 5'd0;
    cycle();
    set_wr(1'b1, 2'd1, 2'd0, 3'd0, 5'd0, 5'd5, 32'h12345678, 32'h0, 32'h100);
    cycle();
    set_idle();
    #1;
    check("dir_r5", rd1, 32'h12345678);
    check("dir_r0", rd2, 32'h0);
    cycle();

    // Load extension
    set_wr(1'b1, 2'd0, 2'd1, 3'd2, 5'd8, 5'd0, 32'h00000003, 32'h80FF7F01, 32'h104);
    cycle();
    set_wr(1'b1, 2'd0, 2'd1, 3'd3, 5'd9, 5'd0, 32'h00000000, 32'h80FF7F01, 32'h108);
    cycle();
    set_wr(1'b1, 2'd0, 2'd1, 3'd4, 5'd10, 5'd0, 32'h00000002, 32'h80FF7F01, 32'h10C);
    cycle();
    set_idle(); ra1 = 5'd8; ra2 = 5'd9;
    #1;
    check("dir_lb", rd1, 32'hFFFFFF80);
    check("dir_lhu", rd2, 32'h00007F01);
    cycle();
    ra1 = 5'd10;
    #1;
    check("dir_lh", rd1, 32'hFFFF80FF);
    cycle();

    // jal, then a $0 write that must not be traced
    do_reset();
    set_wr(1'b1, 2'd2, 2'd2, 3'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h00003000);
    cycle();
    set_wr(1'b1, 2'd1, 2'd0, 3'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h3004);
    ra1 = 5'd31; ra2 = 5'd0;
    #1;
    check("dir_jal", rd1, 32'h00003008);
    check("dir_r0_w", rd2, 32'h0);
`ifdef GRF_TRACE_EN
    check("dir_jal_pc", trace_pc, 32'h00003000);
    check("dir_jal_reg", {27'b0, trace_reg}, 32'd31);
    check("dir_jal_data", trace_data, 32'h00003008);
`endif
    cycle();
    set_idle();
    cycle();

    // Same-cycle bypass vs. no bypass
    set_wr(1'b1, 2'd1, 2'd0, 3'd0, 5'd0, 5'd7, 32'h11111111, 32'h0, 32'h200);
    cycle();
    set_wr(1'b1, 2'd1, 2'd0, 3'd0, 5'd0, 5'd7, 32'hAAAA5555, 32'h0, 32'h204);
    ra1 = 5'd7;
    #1;
    check("dir_bypass", rd1, 32'hAAAA5555);
    check("dir_nobypass", rd1_nb, 32'h11111111);
    cycle();
    set_idle();
    cycle();

    // Overflow: nine commits with the consumer stalled, then drain
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_wr(1'b1, 2'd1, 2'd0, 3'd0, 5'd0, 5'(i + 1), $urandom, 32'h0, 32'h400 + 32'(4 * i));
      if (i < 8) first8[i] = w_alu;
      cycle();
    end
    set_idle();
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
`ifdef GRF_TRACE_EN
      check("ovf_valid", {31'b0, trace_valid}, 32'h1);
      check("ovf_flag", {31'b0, trace_overflow}, 32'h1);
      check("ovf_order", trace_data, first8[i]);
`endif
      cycle();
    end
    do_reset();
    #1;
    check("rst_valid", {31'b0, trace_valid}, 32'h0);
    check("rst_ovf", {31'b0, trace_overflow}, 32'h0);
    cycle();

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_wr(reset ? 1'b0 : 1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
             3'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      ra1 = ($urandom_range(0, 2) == 0) ? model_dest() : 5'($urandom);
      ra2 = ($urandom_range(0, 2) == 0) ? model_dest() : 5'($urandom);
      trace_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
